poly_synth: RTL

POLY_SYNTH -- requirements
Module: poly_synth

---
 rtl/poly_synth.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/poly_synth.sv
// rtl/poly_synth.sv - polyphonic square/sawtooth synthesiser with PWM output
//
// Keys are registered once (S0), the lowest NUM_VOICES set keys are assigned
// to voices in ascending order, each voice runs a 24-bit phase accumulator,
// the voice samples are averaged and the average drives a free-running PWM.
//
// Ports:
//   clk       - single clock, all state on the rising edge
//   RST       - synchronous active-high reset
//   NOTES     - key k pressed when bit k is 1 (bit 0 = C4, one semitone per bit)
//   MODE      - 0 square wave, 1 sawtooth
//   OCTAVE    - 1 doubles every voice increment
//   pwm_o     - PWM audio output
//   voices_o  - bit v set while voice v holds a key
//
// Optional: define POLY_SYNTH_KEY_SYNC_EN to add a 2-flop synchroniser ahead
// of S0 (NOTES-to-voices_o latency becomes 4 cycles instead of 2).

module poly_synth #(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4,
  parameter int PWM_W      = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [NUM_KEYS-1:0]   NOTES,
  input  logic                  MODE,
  input  logic                  OCTAVE,
  output logic                  pwm_o,
  output logic [NUM_VOICES-1:0] voices_o
);

  localparam int SHIFT = $clog2(NUM_VOICES);
  localparam int SUM_W = PWM_W + 4;
  localparam int IN_W  = NUM_KEYS + 2;

  // Tuning words: round(261.63 * 2^(k/12) * 2^24 / 1e7)
  function automatic logic [10:0] tw_lookup(input logic [3:0] k);
    case (k)
      4'd0:    return 11'd439;
      4'd1:    return 11'd465;
      4'd2:    return 11'd493;
      4'd3:    return 11'd522;
      4'd4:    return 11'd553;
      4'd5:    return 11'd586;
      4'd6:    return 11'd621;
      4'd7:    return 11'd658;
      4'd8:    return 11'd697;
      4'd9:    return 11'd738;
      4'd10:   return 11'd782;
      4'd11:   return 11'd829;
      4'd12:   return 11'd878;
      4'd13:   return 11'd930;
      4'd14:   return 11'd985;
      default: return 11'd1044;
    endcase
  endfunction

  logic [IN_W-1:0]     key_in;
  logic [NUM_KEYS-1:0] notes_s0;
  logic                mode_s0;
  logic                oct_s0;

`ifdef POLY_SYNTH_KEY_SYNC_EN
  logic [IN_W-1:0] sync1;
  logic [IN_W-1:0] sync2;

  always_ff @(posedge clk) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {OCTAVE, MODE, NOTES};
      sync2 <= sync1;
    end
  end

  assign key_in = sync2;
`else
  assign key_in = {OCTAVE, MODE, NOTES};
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      notes_s0 <= '0;
      mode_s0  <= 1'b0;
      oct_s0   <= 1'b0;
    end else begin
      {oct_s0, mode_s0, notes_s0} <= key_in;
    end
  end

  // Allocator: voice v takes the (v+1)-th lowest set key; extra keys are dropped.
  logic [3:0]            nxt_idx [NUM_VOICES];
  logic [NUM_VOICES-1:0] nxt_act;

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      int cnt;
      nxt_idx[v] = '0;
      nxt_act[v] = 1'b0;
      cnt = 0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (notes_s0[k]) begin
          if (cnt == v) begin
            nxt_idx[v] = 4'(k);
            nxt_act[v] = 1'b1;
          end
          cnt = cnt + 1;
        end
      end
    end
  end

  logic [3:0]            key_idx [NUM_VOICES];
  logic [NUM_VOICES-1:0] active;
  logic [23:0]           phase   [NUM_VOICES];
  logic [23:0]           inc     [NUM_VOICES];
  logic [PWM_W-1:0]      sample  [NUM_VOICES];
  logic [SUM_W-1:0]      sum;

  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      inc[v]    = {13'd0, tw_lookup(key_idx[v])} << oct_s0;
      sample[v] = mode_s0 ? phase[v][23 -: PWM_W] : {PWM_W{phase[v][23]}};
      sum       = sum + SUM_W'(sample[v]);
    end
  end

  // A voice restarts from phase 0 whenever its allocation changes (including
  // becoming active or inactive); otherwise it keeps accumulating.
  always_ff @(posedge clk) begin
    if (RST) begin
      active <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_idx[v] <= '0;
        phase[v]   <= '0;
      end
    end else begin
      active <= nxt_act;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_idx[v] <= nxt_idx[v];
        if ((nxt_act[v] != active[v]) || (nxt_idx[v] != key_idx[v]) || !active[v])
          phase[v] <= '0;
        else
          phase[v] <= phase[v] + inc[v];
      end
    end
  end

  assign voices_o = active;

  // Mixer and PWM. The duty used for a whole PWM period is the mixer value seen
  // when the counter is 0, so the compare at count 0 already uses the new duty.
  logic [PWM_W-1:0] mix;
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] duty_now;
  logic [PWM_W-1:0] pwm_cnt;

  assign duty_now = (pwm_cnt == '0) ? mix : duty;

  always_ff @(posedge clk) begin
    if (RST) begin
      mix     <= '0;
      duty    <= '0;
      pwm_cnt <= '0;
      pwm_o   <= 1'b0;
    end else begin
      mix     <= PWM_W'(sum >> SHIFT);
      duty    <= duty_now;
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      pwm_o   <= (pwm_cnt < duty_now);
    end
  end

endmodule
